tx_ds_char: RTL and testbench

Parametrised IEEE-1355 DS-SE character-level transmitter. It accepts data and control characters over a valid/ready handshake, adds odd parity and the flag bit, and serialises each character LSB-first onto Data/Strobe lines. When the link is idle it inserts NULLs automatically, and it emulates a disconnect when disabled. It sits between the link state machine / transmit FIFO and the pads, replacing the bit-level DS transmitter.

---
 rtl/tx_ds_pkg.sv | 21 ++
 rtl/tx_ds_char_if.sv | 12 +
 rtl/tx_bit_strobe.sv | 27 ++
 rtl/tx_ds_char.sv | 121 ++++++++++++
 tb/tb_tx_ds_char.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/tx_ds_pkg.sv
// Shared constants and helpers for the DS-SE character transmitter.
package tx_ds_pkg;

  localparam logic [1:0] CTL_FCT  = 2'b00;
  localparam logic [1:0] CTL_EOP1 = 2'b01;
  localparam logic [1:0] CTL_EOP2 = 2'b10;
  localparam logic [1:0] CTL_ESC  = 2'b11;

  localparam int unsigned CTL_CHAR_LEN = 4;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } txState_e;

  // Data character = parity + flag + payload.
  function automatic int unsigned data_char_len(input int unsigned dataBits);
    return dataBits + 32'd2;
  endfunction

endpackage

// File: rtl/tx_ds_char_if.sv
// Character handshake between the link FSM / TX FIFO and the DS transmitter.
interface tx_ds_char_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 TxValid;
  logic                 TxIsCtl;
  logic [DATA_BITS-1:0] TxData;
  logic                 TxReady;

  modport master (output TxValid, output TxIsCtl, output TxData, input TxReady);
  modport slave  (input TxValid, input TxIsCtl, input TxData, output TxReady);
endinterface

// File: rtl/tx_bit_strobe.sv
// Bit-rate divider: one-cycle strobe every BIT_DIV TxClk cycles, restartable.
module tx_bit_strobe #(
  parameter int unsigned BIT_DIV = 1
) (
  input  logic TxClk,
  input  logic TxReset,
  input  logic Clear,
  output logic BitStrobe_c
);

  localparam int unsigned CntW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

  logic [CntW-1:0] divCnt;

  assign BitStrobe_c = ~TxReset & ~Clear & (divCnt == CntW'(BIT_DIV - 1));

  always_ff @(posedge TxClk or posedge TxReset) begin
    if (TxReset) begin
      divCnt <= '0;
    end else if (Clear || BitStrobe_c) begin
      divCnt <= '0;
    end else begin
      divCnt <= divCnt + CntW'(1);
    end
  end

endmodule

// File: rtl/tx_ds_char.sv
// IEEE-1355 DS-SE character transmitter: parity/flag framing, LSB-first
// serialisation, automatic NULL insertion and disconnect on disable.
module tx_ds_char
  import tx_ds_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned BIT_DIV   = 1
) (
  input  logic         TxClk,
  input  logic         TxReset,
  input  logic         TxEnable,
  tx_ds_char_if.slave  txIf,
  output logic         D,
  output logic         S
);

  localparam int unsigned DataLen = data_char_len(DATA_BITS);
  localparam int unsigned ShW     = DataLen;
  localparam int unsigned RemW    = $clog2(DataLen);

  logic            bitStrobe_c;
  logic            strobeClear;
  txState_e        curState;
  logic [ShW-1:0]  shiftReg, shiftNext;
  logic [RemW-1:0] remaining, remNext;
  logic            nullFctPending, flagNext;
  logic            parityHist, parNext;
  logic            dNext, sNext;
  logic [ShW-1:0]  curChar;
  logic            bitOut;
  logic            isCtl;
  logic [1:0]      ctlCode;

  assign strobeClear = ~TxEnable;

  tx_bit_strobe #(.BIT_DIV(BIT_DIV)) uBitStrobe (
    .TxClk       (TxClk),
    .TxReset     (TxReset),
    .Clear       (strobeClear),
    .BitStrobe_c (bitStrobe_c)
  );

  assign curState     = (remaining == '0) ? TX_IDLE : TX_SEND;
  assign txIf.TxReady = TxEnable & bitStrobe_c & (curState == TX_IDLE) & ~nullFctPending;

  // Character selection, serialisation and DS encoding.
  always_comb begin
    shiftNext = shiftReg;
    remNext   = remaining;
    flagNext  = nullFctPending;
    parNext   = parityHist;
    dNext     = D;
    sNext     = S;
    curChar   = '0;
    bitOut    = 1'b0;
    isCtl     = 1'b1;
    ctlCode   = CTL_ESC;

    if (!TxEnable) begin
      shiftNext = '0;
      remNext   = '0;
      flagNext  = 1'b0;
      parNext   = 1'b0;
      dNext     = 1'b0;
      sNext     = 1'b0;
    end else if (bitStrobe_c) begin
      case (curState)
        TX_IDLE: begin
          // Forced FCT half of a NULL beats the host; an empty slot starts a NULL.
          if (nullFctPending) begin
            ctlCode  = CTL_FCT;
            flagNext = 1'b0;
          end else if (txIf.TxValid) begin
            isCtl   = txIf.TxIsCtl;
            ctlCode = txIf.TxData[1:0];
          end else begin
            flagNext = 1'b1;
          end

          if (isCtl) begin
            curChar = ShW'({ctlCode, 1'b1, ~(parityHist ^ 1'b1)});
            remNext = RemW'(CTL_CHAR_LEN - 1);
            parNext = ^ctlCode;
          end else begin
            curChar = {txIf.TxData, 1'b0, ~parityHist};
            remNext = RemW'(DataLen - 1);
            parNext = ^txIf.TxData;
          end
          bitOut    = curChar[0];
          shiftNext = curChar >> 1;
        end
        default: begin
          bitOut    = shiftReg[0];
          shiftNext = shiftReg >> 1;
          remNext   = remaining - RemW'(1);
        end
      endcase
      dNext = bitOut;
      sNext = S ^ ~(D ^ bitOut);
    end
  end

  always_ff @(posedge TxClk or posedge TxReset) begin
    if (TxReset) begin
      shiftReg       <= '0;
      remaining      <= '0;
      nullFctPending <= 1'b0;
      parityHist     <= 1'b0;
      D              <= 1'b0;
      S              <= 1'b0;
    end else begin
      shiftReg       <= shiftNext;
      remaining      <= remNext;
      nullFctPending <= flagNext;
      parityHist     <= parNext;
      D              <= dNext;
      S              <= sNext;
    end
  end

endmodule

// File: tb/tb_tx_ds_char.sv
// Directed bench for tx_ds_char: NULL stream, data/control framing,
// NULL interlock, disable/re-enable, slow bit rate and async reset.
module tb_tx_ds_char;

  logic TxClk = 1'b0;
  always #5 TxClk = ~TxClk;

  logic rstA, enA, dA, sA;
  logic rstB, enB, dB, sB;

  tx_ds_char_if #(.DATA_BITS(8)) ifA ();
  tx_ds_char_if #(.DATA_BITS(4)) ifB ();

  tx_ds_char #(.DATA_BITS(8), .BIT_DIV(1)) dutA (
    .TxClk(TxClk), .TxReset(rstA), .TxEnable(enA), .txIf(ifA), .D(dA), .S(sA)
  );

  tx_ds_char #(.DATA_BITS(4), .BIT_DIV(3)) dutB (
    .TxClk(TxClk), .TxReset(rstB), .TxEnable(enB), .txIf(ifB), .D(dB), .S(sB)
  );

  int   passCnt  = 0;
  int   totalCnt = 0;
  logic expD, expS;
  logic expR;

  // Advance one bit on DUT A and fold the expected bit into the D/S model.
  task automatic tick_a(input logic b);
    @(posedge TxClk);
    #1;
    expS = expS ^ ~(expD ^ b);
    expD = b;
  endtask

  task automatic test_reset();
    rstA = 1'b1; enA = 1'b1;
    ifA.TxValid = 1'b0; ifA.TxIsCtl = 1'b0; ifA.TxData = 8'h00;
    rstB = 1'b1; enB = 1'b0;
    ifB.TxValid = 1'b0; ifB.TxIsCtl = 1'b0; ifB.TxData = 4'h0;
    repeat (2) @(posedge TxClk);
    #1;
    expD = 1'b0; expS = 1'b0;
    totalCnt++;
    if (dA !== 1'b0) $display("FAIL reset D: got %b want 0", dA); else passCnt++;
    totalCnt++;
    if (sA !== 1'b0) $display("FAIL reset S: got %b want 0", sA); else passCnt++;
    totalCnt++;
    if (ifA.TxReady !== 1'b0) $display("FAIL reset TxReady: got %b want 0", ifA.TxReady); else passCnt++;
  endtask

  task automatic test_null_idle();
    bit nullV [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    rstA = 1'b0;
    for (int i = 0; i < 24; i++) begin
      ifA.TxValid = 1'b0;
      #1;
      expR = ((i % 8) == 0);
      totalCnt++;
      if (ifA.TxReady !== expR) $display("FAIL null ready[%0d]: got %b want %b", i, ifA.TxReady, expR); else passCnt++;
      tick_a(nullV[i % 8]);
      totalCnt++;
      if (dA !== expD) $display("FAIL null D[%0d]: got %b want %b", i, dA, expD); else passCnt++;
      totalCnt++;
      if (sA !== expS) $display("FAIL null S[%0d]: got %b want %b", i, sA, expS); else passCnt++;
    end
  endtask

  task automatic test_data_a5();
    bit dv [18] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                    1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 18; i++) begin
      ifA.TxValid = (i == 0); ifA.TxIsCtl = 1'b0; ifA.TxData = 8'hA5;
      #1;
      expR = (i == 0 || i == 10);
      totalCnt++;
      if (ifA.TxReady !== expR) $display("FAIL a5 ready[%0d]: got %b want %b", i, ifA.TxReady, expR); else passCnt++;
      tick_a(dv[i]);
      totalCnt++;
      if (dA !== expD) $display("FAIL a5 D[%0d]: got %b want %b", i, dA, expD); else passCnt++;
      totalCnt++;
      if (sA !== expS) $display("FAIL a5 S[%0d]: got %b want %b", i, sA, expS); else passCnt++;
    end
    ifA.TxValid = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit dv [22] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    1'b1, 1'b1, 1'b0, 1'b0,
                    1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 22; i++) begin
      ifA.TxValid = (i <= 10);
      ifA.TxIsCtl = (i >= 1);
      ifA.TxData  = (i == 0) ? 8'h01 : 8'h00;
      #1;
      expR = (i == 0 || i == 10 || i == 14);
      totalCnt++;
      if (ifA.TxReady !== expR) $display("FAIL b2b ready[%0d]: got %b want %b", i, ifA.TxReady, expR); else passCnt++;
      tick_a(dv[i]);
      totalCnt++;
      if (dA !== expD) $display("FAIL b2b D[%0d]: got %b want %b", i, dA, expD); else passCnt++;
      totalCnt++;
      if (sA !== expS) $display("FAIL b2b S[%0d]: got %b want %b", i, sA, expS); else passCnt++;
    end
    ifA.TxValid = 1'b0; ifA.TxIsCtl = 1'b0;
  endtask

  task automatic test_null_interlock();
    bit dv [26] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                    1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 26; i++) begin
      ifA.TxValid = (i >= 2 && i <= 8); ifA.TxIsCtl = 1'b0; ifA.TxData = 8'h3C;
      #1;
      expR = (i == 0 || i == 8 || i == 18);
      totalCnt++;
      if (ifA.TxReady !== expR) $display("FAIL lock ready[%0d]: got %b want %b", i, ifA.TxReady, expR); else passCnt++;
      tick_a(dv[i]);
      totalCnt++;
      if (dA !== expD) $display("FAIL lock D[%0d]: got %b want %b", i, dA, expD); else passCnt++;
      totalCnt++;
      if (sA !== expS) $display("FAIL lock S[%0d]: got %b want %b", i, sA, expS); else passCnt++;
    end
    ifA.TxValid = 1'b0;
  endtask

  task automatic test_disable();
    bit dv [3] = '{1'b1, 1'b0, 1'b1};
    bit nullV [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      ifA.TxValid = (i == 0); ifA.TxIsCtl = 1'b0; ifA.TxData = 8'h07;
      #1;
      expR = (i == 0);
      totalCnt++;
      if (ifA.TxReady !== expR) $display("FAIL dis ready[%0d]: got %b want %b", i, ifA.TxReady, expR); else passCnt++;
      tick_a(dv[i]);
      totalCnt++;
      if (dA !== expD) $display("FAIL dis D[%0d]: got %b want %b", i, dA, expD); else passCnt++;
    end
    ifA.TxValid = 1'b0;
    enA = 1'b0;
    #1;
    totalCnt++;
    if (ifA.TxReady !== 1'b0) $display("FAIL dis ready_off: got %b want 0", ifA.TxReady); else passCnt++;
    @(posedge TxClk);
    #1;
    expD = 1'b0; expS = 1'b0;
    totalCnt++;
    if (dA !== 1'b0) $display("FAIL dis D_off: got %b want 0", dA); else passCnt++;
    totalCnt++;
    if (sA !== 1'b0) $display("FAIL dis S_off: got %b want 0", sA); else passCnt++;
    @(posedge TxClk);
    #1;
    enA = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      expR = (i == 0);
      totalCnt++;
      if (ifA.TxReady !== expR) $display("FAIL reen ready[%0d]: got %b want %b", i, ifA.TxReady, expR); else passCnt++;
      tick_a(nullV[i]);
      totalCnt++;
      if (dA !== expD) $display("FAIL reen D[%0d]: got %b want %b", i, dA, expD); else passCnt++;
      totalCnt++;
      if (sA !== expS) $display("FAIL reen S[%0d]: got %b want %b", i, sA, expS); else passCnt++;
    end
  endtask

  task automatic test_slow_rate();
    bit   bv [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic eD = 1'b0;
    logic eS = 1'b0;
    logic eR;
    rstB = 1'b0; enB = 1'b1; ifB.TxIsCtl = 1'b0; ifB.TxData = 4'hA;
    for (int c = 1; c <= 25; c++) begin
      ifB.TxValid = (c <= 3);
      #1;
      eR = (c == 3 || c == 21);
      totalCnt++;
      if (ifB.TxReady !== eR) $display("FAIL slow ready[%0d]: got %b want %b", c, ifB.TxReady, eR); else passCnt++;
      @(posedge TxClk);
      #1;
      if ((c % 3) == 0) begin
        eS = eS ^ ~(eD ^ bv[c / 3 - 1]);
        eD = bv[c / 3 - 1];
      end
      totalCnt++;
      if (dB !== eD) $display("FAIL slow D[%0d]: got %b want %b", c, dB, eD); else passCnt++;
      totalCnt++;
      if (sB !== eS) $display("FAIL slow S[%0d]: got %b want %b", c, sB, eS); else passCnt++;
    end
    ifB.TxValid = 1'b0;
    rstB = 1'b1;
    #1;
    totalCnt++;
    if (dB !== 1'b0) $display("FAIL async_rst D: got %b want 0", dB); else passCnt++;
    totalCnt++;
    if (sB !== 1'b0) $display("FAIL async_rst S: got %b want 0", sB); else passCnt++;
  endtask

  initial begin
    test_reset();
    test_null_idle();
    test_data_a5();
    test_back_to_back();
    test_null_interlock();
    test_disable();
    test_slow_rate();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
